// File: rtl/final_norm_pipe.sv
// Three-stage normalizer: sign/magnitude, leading-one shift, rounding (RNE by default).
// Define FINAL_NORM_RTZ_EN to add the rnd_mode port (1 = round toward zero).
module final_norm_pipe #(
    parameter int unsigned SUM_W     = 19,
    parameter int unsigned MAN_W     = 11,
    parameter int unsigned POINT_POS = 13,
    parameter int unsigned EXP_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
`ifdef FINAL_NORM_RTZ_EN
    input  logic             rnd_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp_diff,
    output logic             out_exp_carry,
    output logic             out_sign,
    output logic             out_zero
);

    localparam int unsigned POS_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;
    localparam int unsigned EXT_W = SUM_W + MAN_W + 1;
    localparam logic [POS_W-1:0] TOP_POS = POS_W'(SUM_W - 1);
    localparam logic [EXP_W-1:0] POINT_E = EXP_W'(POINT_POS);

    logic w_adv;
    logic w_rnd_in;

`ifdef FINAL_NORM_RTZ_EN
    assign w_rnd_in = rnd_mode;
`else
    assign w_rnd_in = 1'b0;
`endif

    // Stage 1 registers
    logic             r_v1;
    logic             r_sign1;
    logic             r_rnd1;
    logic [SUM_W-1:0] r_mag1;

    // Stage 2 registers
    logic             r_v2;
    logic             r_sign2;
    logic             r_rnd2;
    logic             r_zero2;
    logic [MAN_W-1:0] r_mant2;
    logic [EXP_W-1:0] r_exp2;
    logic             r_round2;
    logic             r_sticky2;

    // Stage 3 (output) registers
    logic             r_v3;
    logic [MAN_W-1:0] r_mant3;
    logic [EXP_W-1:0] r_exp3;
    logic             r_carry3;
    logic             r_sign3;
    logic             r_zero3;

    assign w_adv    = !r_v3 || out_ready;
    assign in_ready = w_adv;

    // S1: sign and magnitude; the most-negative input keeps its top bit as magnitude.
    logic             w_sign_in;
    logic [SUM_W-1:0] w_mag_in;

    assign w_sign_in = in_sum[SUM_W-1];
    assign w_mag_in  = w_sign_in ? (-in_sum) : in_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_sign1 <= 1'b0;
            r_rnd1  <= 1'b0;
            r_mag1  <= '0;
        end else if (w_adv) begin
            r_v1    <= in_valid;
            r_sign1 <= w_sign_in;
            r_rnd1  <= w_rnd_in;
            r_mag1  <= w_mag_in;
        end
    end

    // S2: leading-one detect, left-justify, extract mantissa/round/sticky.
    logic [POS_W-1:0] w_pos;
    logic [SUM_W-1:0] w_norm;
    logic [EXT_W-1:0] w_ext;
    logic [MAN_W-1:0] w_mant_pre;
    logic             w_round_pre;
    logic             w_sticky_pre;
    logic             w_zero_pre;
    logic [EXP_W-1:0] w_exp_pre;

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < int'(SUM_W); i++) begin
            if (r_mag1[i]) begin
                w_pos = POS_W'(i);
            end
        end
    end

    assign w_zero_pre = (r_mag1 == '0);
    assign w_norm     = r_mag1 << (TOP_POS - w_pos);
    // Zero padding below the sum supplies the right-fill when few bits follow the leading one.
    assign w_ext        = {w_norm, {(MAN_W + 1){1'b0}}};
    assign w_mant_pre   = w_ext[EXT_W-1 -: MAN_W];
    assign w_round_pre  = w_ext[EXT_W-1-MAN_W];
    assign w_sticky_pre = |w_ext[EXT_W-2-MAN_W:0];
    assign w_exp_pre    = w_zero_pre ? '0 : (EXP_W'(w_pos) - POINT_E);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2      <= 1'b0;
            r_sign2   <= 1'b0;
            r_rnd2    <= 1'b0;
            r_zero2   <= 1'b0;
            r_mant2   <= '0;
            r_exp2    <= '0;
            r_round2  <= 1'b0;
            r_sticky2 <= 1'b0;
        end else if (w_adv) begin
            r_v2      <= r_v1;
            r_sign2   <= r_sign1;
            r_rnd2    <= r_rnd1;
            r_zero2   <= w_zero_pre;
            r_mant2   <= w_mant_pre;
            r_exp2    <= w_exp_pre;
            r_round2  <= w_round_pre;
            r_sticky2 <= w_sticky_pre;
        end
    end

    // S3: rounding; an overflow to 2^MAN_W renormalizes and flags the exponent carry.
    logic             w_inc;
    logic [MAN_W:0]   w_rounded;
    logic [MAN_W-1:0] w_mant_fin;
    logic             w_carry_fin;

    assign w_inc     = !r_rnd2 && r_round2 && (r_sticky2 || r_mant2[0]);
    assign w_rounded = {1'b0, r_mant2} + {{MAN_W{1'b0}}, w_inc};

    always_comb begin
        w_mant_fin  = w_rounded[MAN_W-1:0];
        w_carry_fin = 1'b0;
        if (w_rounded[MAN_W]) begin
            w_mant_fin  = w_rounded[MAN_W:1];
            w_carry_fin = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3     <= 1'b0;
            r_mant3  <= '0;
            r_exp3   <= '0;
            r_carry3 <= 1'b0;
            r_sign3  <= 1'b0;
            r_zero3  <= 1'b0;
        end else if (w_adv) begin
            r_v3     <= r_v2;
            r_mant3  <= w_mant_fin;
            r_exp3   <= r_exp2;
            r_carry3 <= w_carry_fin;
            r_sign3  <= r_sign2;
            r_zero3  <= r_zero2;
        end
    end

    assign out_valid     = r_v3;
    assign out_mant      = r_mant3;
    assign out_exp_diff  = r_exp3;
    assign out_exp_carry = r_carry3;
    assign out_sign      = r_sign3;
    assign out_zero      = r_zero3;

endmodule

// File: tb/tb_final_norm_pipe.sv
// Scoreboard bench for final_norm_pipe: arithmetic reference model, directed and random traffic.
module tb_final_norm_pipe;

    localparam int SUM_W     = 19;
    localparam int MAN_W     = 11;
    localparam int POINT_POS = 13;
    localparam int EXP_W     = 5;
`ifdef FINAL_NORM_RTZ_EN
    localparam bit RTZ = 1'b1;
`else
    localparam bit RTZ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             rnd_mode;
    logic             out_valid;
    logic             out_ready;
    logic [MAN_W-1:0] out_mant;
    logic [EXP_W-1:0] out_exp_diff;
    logic             out_exp_carry;
    logic             out_sign;
    logic             out_zero;

    final_norm_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sum       (in_sum),
`ifdef FINAL_NORM_RTZ_EN
        .rnd_mode     (rnd_mode),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mant     (out_mant),
        .out_exp_diff (out_exp_diff),
        .out_exp_carry(out_exp_carry),
        .out_sign     (out_sign),
        .out_zero     (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [MAN_W-1:0] mant;
        logic [EXP_W-1:0] exp;
        logic             carry;
        logic             sign;
        logic             zero;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: exact arithmetic on the integer value, rounding by remainder vs half-ulp.
    function automatic res_t model(input logic [SUM_W-1:0] s, input logic rtz);
        res_t   r;
        longint v, mag, m, rem, half;
        int     p, sh;
        r = '0;
        v = longint'($signed(s));
        if (v == 0) begin
            r.zero = 1'b1;
            return r;
        end
        r.sign = (v < 0);
        mag    = (v < 0) ? -v : v;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        r.exp = EXP_W'(p - POINT_POS);
        if (p >= MAN_W - 1) begin
            sh  = p - (MAN_W - 1);
            m   = mag >> sh;
            rem = mag - (m << sh);
            if (sh > 0 && !rtz) begin
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
            end
        end else begin
            m = mag << ((MAN_W - 1) - p);
        end
        if (m == (longint'(1) << MAN_W)) begin
            m       = m / 2;
            r.carry = 1'b1;
        end
        r.mant = MAN_W'(m);
        return r;
    endfunction

    function automatic res_t cur_out();
        res_t r;
        r.mant  = out_mant;
        r.exp   = out_exp_diff;
        r.carry = out_exp_carry;
        r.sign  = out_sign;
        r.zero  = out_zero;
        return r;
    endfunction

    // Monitor: everything sampled on the falling edge reflects what the next rising edge sees.
    res_t prev_out;
    bit   have_prev = 1'b0;

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            exp_q.delete();
            have_prev = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                check("in_ready_while_stalled", 64'(in_ready), 64'd0);
                if (have_prev) check("stable_while_stalled", 64'(cur_out()), 64'(prev_out));
                prev_out  = cur_out();
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(cur_out()), 64'd0 - 1);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    check("scoreboard_result", 64'(cur_out()), 64'(e));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_sum, rnd_mode & RTZ));
        end
    end

    // Call at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [SUM_W-1:0] s, input logic r);
        int n = 0;
        in_valid = 1'b1;
        in_sum   = s;
        rnd_mode = r;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic direct(input string name, input logic [SUM_W-1:0] s, input logic r,
                          input res_t want);
        int n = 0;
        out_ready = 1'b1;
        send(s, r);
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check({name, "_latency"}, 64'(n), 64'd3);
        check(name, 64'(cur_out()), 64'(want));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic res_t mk(input logic [MAN_W-1:0] m, input logic [EXP_W-1:0] e,
                                input logic c, input logic sg, input logic z);
        res_t r;
        r.mant  = m;
        r.exp   = e;
        r.carry = c;
        r.sign  = sg;
        r.zero  = z;
        return r;
    endfunction

    bit rand_done;

    initial begin
        int base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        rnd_mode  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", 64'(cur_out()), 64'd0);
        @(posedge clk);
        #1;

        direct("unity", 19'h02000, 1'b0, mk(11'h400, 5'd0, 1'b0, 1'b0, 1'b0));
        direct("minus_one", 19'h7FFFF, 1'b0, mk(11'h400, 5'b10011, 1'b0, 1'b1, 1'b0));
        direct("tie_odd", 19'h3FFC0, 1'b0, mk(11'h400, 5'd4, 1'b1, 1'b0, 1'b0));
        direct("tie_even", 19'h20040, 1'b0, mk(11'h400, 5'd4, 1'b0, 1'b0, 1'b0));
        direct("most_negative", 19'h40000, 1'b0, mk(11'h400, 5'd5, 1'b0, 1'b1, 1'b0));
        direct("zero", 19'h00000, 1'b0, mk(11'h000, 5'd0, 1'b0, 1'b0, 1'b1));
        if (RTZ) direct("rtz_tie_odd", 19'h3FFC0, 1'b1, mk(11'h7FF, 5'd4, 1'b0, 1'b0, 1'b0));

        // Back-to-back burst into a stalled consumer
        base      = popped;
        out_ready = 1'b0;
        fork
            begin
                send(19'h02000, 1'b0);
                send(19'h04000, 1'b0);
                send(19'h01000, 1'b0);
                send(19'h00008, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("stall_drain");
        check("stall_delivered_count", 64'(popped - base), 64'd4);

        // Reset with results in flight
        out_ready = 1'b1;
        send(19'h02000, 1'b0);
        send(19'h3FFC0, 1'b0);
        send(19'h7FFFF, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);
        check("post_reset_outputs", 64'(cur_out()), 64'd0);
        repeat (4) begin
            @(negedge clk);
            check("no_stale_after_reset", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        direct("after_reset", 19'h04000, 1'b0, mk(11'h400, 5'd1, 1'b0, 1'b0, 1'b0));

        // Random traffic with random back-pressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [SUM_W-1:0] s;
                    int               kind;
                    kind = $urandom_range(0, 5);
                    case (kind)
                        0:       s = SUM_W'($urandom);
                        1:       s = SUM_W'($urandom_range(0, 255));
                        2:       s = '0;
                        3:       s = 19'h40000;
                        4:       s = SUM_W'(1) << $urandom_range(0, SUM_W - 2);
                        default: s = (SUM_W'($urandom) & ~19'h0007F) | 19'h00040;
                    endcase
                    if (kind == 4 && $urandom_range(0, 1) == 1) s = -s;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(s, 1'($urandom_range(0, 1)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/final_norm_pipe.md
FINAL_NORM_PIPE -- requirements
Module: final_norm_pipe

Interface
REQ-001 Parameter SUM_W, default 19: two's-complement sum width.
REQ-002 Parameter MAN_W, default 11: normalized mantissa width, leading one included.
REQ-003 Parameter POINT_POS, default 13: sum bit position that means zero shift.
REQ-004 Parameter EXP_W, default 5: signed exponent-adjust width.
  - Must hold the range -POINT_POS .. SUM_W-1-POINT_POS.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  in_sum is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_sum this cycle.
REQ-009 in_sum  input  SUM_W  signed sum to normalize.
REQ-010 out_valid  output  1  result outputs are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_mant  output  MAN_W  rounded mantissa with leading one at bit MAN_W-1.
REQ-013 out_exp_diff  output  EXP_W  signed exponent adjust, equal to leading-one position minus POINT_POS.
REQ-014 out_exp_carry  output  1  rounding overflowed; consumer adds 1 to the exponent.
REQ-015 out_sign  output  1  sign of in_sum.
REQ-016 out_zero  output  1  in_sum was zero.

Function
REQ-017 Three-stage pipeline with fixed latency of 3 cycles from an accepted input to out_valid.
  - S1: sign and magnitude.
  - S2: leading-one detect and shift.
  - S3: rounding.
REQ-018 Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv.
  - All stage registers and stage valid bits update only when adv=1.
REQ-019 Transfer rules.
  - An input is accepted iff in_valid && in_ready.
  - A result is consumed iff out_valid && out_ready.
  - When adv=0, the pipeline holds and out_* stay stable.
REQ-020 Bubbles propagate as cleared stage valid bits; throughput is one result per cycle when out_ready=1.
REQ-021 Magnitude = sign ? -in_sum : in_sum, computed as SUM_W-bit unsigned.
  - Most-negative input yields bit SUM_W-1 set, and that bit is included in the search.
REQ-022 Leading-one search covers bits SUM_W-1..0.
  - Pre-round mantissa = the MAN_W bits starting at the leading one.
  - If fewer than MAN_W bits exist below the leading one, pad with zeros on the right.
REQ-023 Rounding bits.
  - Round bit = the bit directly below the mantissa LSB.
  - Sticky = OR of all lower bits.
  - Round and sticky are 0 when those bits do not exist.
REQ-024 Default rounding is round-to-nearest-even: increment iff round && (sticky || mant_lsb).
REQ-025 Rounding overflow (result = 2^MAN_W) handling:
  - out_mant = rounded[MAN_W:1];
  - out_exp_carry = 1;
  - out_exp_diff is not altered.
REQ-026 Zero input gives out_mant=0, out_exp_diff=0, out_exp_carry=0, out_sign=0, out_zero=1.
REQ-027 When in_valid=1 and out_ready=0 with out_valid=1 in the same cycle, the input is not accepted.

Reset
REQ-028 When rst=1 at a clock edge:
  - all stage valid bits and out_valid clear to 0;
  - out_mant, out_exp_diff, out_exp_carry, out_sign and out_zero clear to 0;
  - any in-flight data is discarded.
REQ-029 in_ready is 1 in the first cycle after reset deasserts.

Configuration
REQ-030 Macro FINAL_NORM_RTZ_EN.
  - When defined: adds input port rnd_mode (1 bit), sampled with in_sum and carried through the pipeline.
    - 0 selects RNE.
    - 1 selects round-toward-zero: mantissa truncated, out_exp_carry=0.
  - When undefined: no rnd_mode port; RNE only.

Verification
All scenarios use default parameters.
REQ-031 in_sum=19'h02000, out_ready=1 -> exactly 3 cycles later:
  - out_mant=11'h400, out_exp_diff=0, out_exp_carry=0, out_sign=0, out_zero=0.
REQ-032 in_sum=19'h7FFFF (-1) -> out_sign=1, out_mant=11'h400, out_exp_diff=-13 (5'b10011).
REQ-033 in_sum=19'h3FFC0 (RNE tie, odd lsb) -> out_mant=11'h400, out_exp_carry=1, out_exp_diff=4.
  - With FINAL_NORM_RTZ_EN and rnd_mode=1 -> out_mant=11'h7FF, out_exp_carry=0.
  - in_sum=19'h20040 (tie, even lsb) -> out_mant=11'h400, out_exp_carry=0.
REQ-034 in_sum=19'h40000 (most negative) -> out_sign=1, out_mant=11'h400, out_exp_diff=5.
  - in_sum=0 -> out_zero=1 with all other outputs 0.
REQ-035 Back-to-back inputs 19'h02000, 19'h04000, 19'h01000, 19'h00008 with out_ready held 0 for 5 cycles, then 1:
  - all four results delivered in order, none dropped or duplicated;
  - out_* stable while stalled;
  - in_ready=0 while out_valid=1 and out_ready=0.
REQ-036 rst asserted one cycle while three results are in flight -> next cycle out_valid=0 and all outputs 0.
  - No stale result ever appears.
  - A new input after reset returns a correct result 3 cycles later.
